// File: rtl/lsu_pkg.sv
// Shared states, fault causes, funct3 encodings and address-window constants
// for the load/store memory stage.
package lsu_pkg;

  localparam logic [31:0] RAM_BASE   = 32'h8000_2000;
  localparam logic [31:0] RAM_BYTES  = 32'd32768;
  localparam logic [31:0] MMIO_BASE  = 32'h1000_0000;
  localparam logic [31:0] MMIO_BYTES = 32'd256;

  localparam logic [2:0] FN3_LB  = 3'd0;
  localparam logic [2:0] FN3_LH  = 3'd1;
  localparam logic [2:0] FN3_LW  = 3'd2;
  localparam logic [2:0] FN3_LBU = 3'd4;
  localparam logic [2:0] FN3_LHU = 3'd5;
  localparam logic [2:0] FN3_SB  = 3'd0;
  localparam logic [2:0] FN3_SH  = 3'd1;
  localparam logic [2:0] FN3_SW  = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAM_ACC,
    ST_RAM_WAIT,
    ST_MMIO,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    FAULT_NONE        = 2'd0,
    FAULT_LD_MISALIGN = 2'd1,
    FAULT_ST_MISALIGN = 2'd2,
    FAULT_ACCESS      = 2'd3
  } fault_e;

  // Subtract-then-compare so a window near the top of the map cannot wrap.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    return (addr >= base) && ((addr - base) < size);
  endfunction

endpackage

// File: rtl/lsu_addr_decode.sv
// Combinational window, funct3 and alignment classification of one request.
// LSU_MISALIGN_TRAP_EN selects trapping (defined) or force-aligning (undefined).
module lsu_addr_decode
  import lsu_pkg::*;
(
  input  logic [31:0] i_addr,
  input  logic        i_we,
  input  logic [2:0]  i_fn3,
  output logic        o_is_ram,
  output logic        o_is_mmio,
  output fault_e      o_fault,
  output logic [31:0] o_addr
);

  logic w_fn3_ok;
  logic w_is_half;
  logic w_is_word;
  logic w_in_ram;
  logic w_in_mmio;

  always_comb begin
    w_fn3_ok  = 1'b0;
    w_is_half = 1'b0;
    w_is_word = 1'b0;
    if (i_we) begin
      case (i_fn3)
        FN3_SB:  w_fn3_ok = 1'b1;
        FN3_SH:  begin w_fn3_ok = 1'b1; w_is_half = 1'b1; end
        FN3_SW:  begin w_fn3_ok = 1'b1; w_is_word = 1'b1; end
        default: w_fn3_ok = 1'b0;
      endcase
    end else begin
      case (i_fn3)
        FN3_LB, FN3_LBU: w_fn3_ok = 1'b1;
        FN3_LH, FN3_LHU: begin w_fn3_ok = 1'b1; w_is_half = 1'b1; end
        FN3_LW:          begin w_fn3_ok = 1'b1; w_is_word = 1'b1; end
        default:         w_fn3_ok = 1'b0;
      endcase
    end
  end

  assign w_in_ram  = in_window(i_addr, RAM_BASE, RAM_BYTES);
  assign w_in_mmio = in_window(i_addr, MMIO_BASE, MMIO_BYTES);

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign = (w_is_half && i_addr[0]) || (w_is_word && (i_addr[1:0] != 2'b00));
  assign o_addr     = i_addr;
`else
  assign o_addr = {i_addr[31:2],
                   i_addr[1] & ~w_is_word,
                   i_addr[0] & ~(w_is_word | w_is_half)};
`endif

  always_comb begin
    o_fault = FAULT_NONE;
    if (!w_fn3_ok || !(w_in_ram || w_in_mmio) || (w_in_mmio && !w_is_word))
      o_fault = FAULT_ACCESS;
`ifdef LSU_MISALIGN_TRAP_EN
    else if (w_misalign)
      o_fault = i_we ? FAULT_ST_MISALIGN : FAULT_LD_MISALIGN;
`endif
  end

  assign o_is_ram  = w_in_ram && (o_fault == FAULT_NONE);
  assign o_is_mmio = w_in_mmio && (o_fault == FAULT_NONE);

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: RAM port, MMIO handshake and tagged response.
// Misaligned handling follows LSU_MISALIGN_TRAP_EN inside lsu_addr_decode.
module lsu_mem_stage
  import lsu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_fn3,
  input  logic [4:0]  i_req_rd,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic [4:0]  o_resp_rd,
  output logic [1:0]  o_resp_fault,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_mem_wr_en,
  output logic [2:0]  o_mem_fn3,
  input  logic [31:0] i_mem_rdata,
  output logic        o_mmio_valid,
  input  logic        i_mmio_ready,
  output logic [31:0] o_mmio_addr,
  output logic [31:0] o_mmio_wdata,
  output logic        o_mmio_we,
  input  logic [31:0] i_mmio_rdata
);

  state_e      r_state;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mmio_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_we;
  logic [2:0]  r_fn3;
  logic [4:0]  r_rd;
  fault_e      r_fault;
  logic        r_resp_valid;
  logic        r_mem_wr_en;
  logic        r_mmio_valid;

  logic        w_is_ram;
  logic        w_is_mmio;
  fault_e      w_fault;
  logic [31:0] w_addr;
  logic        w_accept;

  lsu_addr_decode u_decode (
    .i_addr    (i_req_addr),
    .i_we      (i_req_we),
    .i_fn3     (i_req_fn3),
    .o_is_ram  (w_is_ram),
    .o_is_mmio (w_is_mmio),
    .o_fault   (w_fault),
    .o_addr    (w_addr)
  );

  assign o_req_ready = (r_state == ST_IDLE) && !i_rst;
  assign w_accept    = i_req_valid && o_req_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_mem_addr   <= '0;
      r_mmio_addr  <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_we         <= 1'b0;
      r_fn3        <= '0;
      r_rd         <= '0;
      r_fault      <= FAULT_NONE;
      r_resp_valid <= 1'b0;
      r_mem_wr_en  <= 1'b0;
      r_mmio_valid <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_mem_wr_en  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_mem_addr  <= w_addr - RAM_BASE;
            r_mmio_addr <= w_addr - MMIO_BASE;
            r_wdata     <= i_req_wdata;
            r_we        <= i_req_we;
            r_fn3       <= i_req_fn3;
            r_rd        <= i_req_rd;
            r_fault     <= w_fault;
            r_rdata     <= '0;
            if (w_fault != FAULT_NONE) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
            end else if (w_is_ram) begin
              r_state     <= ST_RAM_ACC;
              r_mem_wr_en <= i_req_we;
            end else if (w_is_mmio) begin
              r_state      <= ST_MMIO;
              r_mmio_valid <= 1'b1;
            end
          end
        end
        ST_RAM_ACC: begin
          if (r_we) begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
          end else begin
            r_state <= ST_RAM_WAIT;
          end
        end
        ST_RAM_WAIT: begin
          r_rdata      <= i_mem_rdata;
          r_state      <= ST_RESP;
          r_resp_valid <= 1'b1;
        end
        ST_MMIO: begin
          if (i_mmio_ready) begin
            r_mmio_valid <= 1'b0;
            if (!r_we) r_rdata <= i_mmio_rdata;
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Strobes are gated by reset so a store or MMIO beat caught by reset never lands.
  assign o_mem_wr_en  = r_mem_wr_en && !i_rst;
  assign o_mmio_valid = r_mmio_valid && !i_rst;

  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_wdata;
  assign o_mem_fn3    = r_fn3;
  assign o_mmio_addr  = r_mmio_addr;
  assign o_mmio_wdata = r_wdata;
  assign o_mmio_we    = r_we;

  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_rdata;
  assign o_resp_rd    = r_rd;
  assign o_resp_fault = r_fault;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: directed cases, reset cases, then random traffic
// against a range/arithmetic reference model with RAM and MMIO peripheral models.
module tb_lsu_mem_stage;

  localparam longint RAM_B  = 64'h8000_2000;
  localparam longint RAM_N  = 32768;
  localparam longint MMIO_B = 64'h1000_0000;
  localparam longint MMIO_N = 256;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        i_req_we;
  logic [2:0]  i_req_fn3;
  logic [4:0]  i_req_rd;
  logic        o_resp_valid;
  logic [31:0] o_resp_rdata;
  logic [4:0]  o_resp_rd;
  logic [1:0]  o_resp_fault;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        o_mem_wr_en;
  logic [2:0]  o_mem_fn3;
  logic [31:0] i_mem_rdata;
  logic        o_mmio_valid;
  logic        i_mmio_ready;
  logic [31:0] o_mmio_addr;
  logic [31:0] o_mmio_wdata;
  logic        o_mmio_we;
  logic [31:0] i_mmio_rdata;

  lsu_mem_stage dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_we(i_req_we),
    .i_req_fn3(i_req_fn3), .i_req_rd(i_req_rd),
    .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata),
    .o_resp_rd(o_resp_rd), .o_resp_fault(o_resp_fault),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wr_en(o_mem_wr_en),
    .o_mem_fn3(o_mem_fn3), .i_mem_rdata(i_mem_rdata),
    .o_mmio_valid(o_mmio_valid), .i_mmio_ready(i_mmio_ready),
    .o_mmio_addr(o_mmio_addr), .o_mmio_wdata(o_mmio_wdata), .o_mmio_we(o_mmio_we),
    .i_mmio_rdata(i_mmio_rdata)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [1:0]  fault;
    logic [31:0] rdata;
    int          exp_cyc;
    bit          via_mmio;
    bit          we;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  fn3;
    logic        we;
    int          cyc;
  } acc_t;

  resp_t resp_q[$];
  acc_t  wr_q[$];
  acc_t  mmio_q[$];
  int          hs_cyc   = 0;
  logic [31:0] hs_rdata = '0;
  int          hold_lo  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Formatted data the RAM model returns for a given offset and funct3.
  function automatic logic [31:0] ram_fmt(input logic [31:0] off, input logic [2:0] f);
    if (off == 32'h10) return 32'hDEAD_BEEF;
    return (off * 32'h9E37_79B1) ^ {29'd0, f} ^ 32'h0F0F_0000;
  endfunction

  // kind: 0 fault response only, 1 RAM access, 2 MMIO access.
  function automatic void model(input logic [31:0] a, input logic we, input logic [2:0] f,
                                output logic [1:0] flt, output int kind, output logic [31:0] off);
    longint la;
    longint sz;
    bit ok, in_ram, in_mmio;
    la      = longint'(a);
    ok      = we ? (f <= 3'd2) : (f != 3'd3 && f != 3'd6 && f != 3'd7);
    sz      = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    in_ram  = (la >= RAM_B) && (la < RAM_B + RAM_N);
    in_mmio = (la >= MMIO_B) && (la < MMIO_B + MMIO_N);
    kind = 0;
    flt  = 2'd3;
    off  = '0;
    if (!ok || !(in_ram || in_mmio) || (in_mmio && sz != 4)) return;
    if (la % sz != 0) begin
`ifdef LSU_MISALIGN_TRAP_EN
      flt = we ? 2'd2 : 2'd1;
      return;
`else
      la = la - (la % sz);
`endif
    end
    flt  = 2'd0;
    kind = in_ram ? 1 : 2;
    off  = in_ram ? 32'(la - RAM_B) : 32'(la - MMIO_B);
  endfunction

  // RAM model: one-cycle read latency from the address/fn3 seen at the edge.
  initial begin
    logic [31:0] a;
    logic [2:0]  f;
    i_mem_rdata = '0;
    forever begin
      @(posedge i_clk);
      a = o_mem_addr;
      f = o_mem_fn3;
      #1;
      i_mem_rdata = ram_fmt(a, f);
    end
  end

  // MMIO peripheral: random ready (also outside transactions), fresh data every cycle.
  initial begin
    i_mmio_ready = 1'b0;
    i_mmio_rdata = '0;
    forever begin
      @(posedge i_clk);
      #1;
      if (hold_lo > 0) begin
        i_mmio_ready = 1'b0;
        hold_lo--;
      end else begin
        i_mmio_ready = 1'($urandom_range(0, 1));
      end
      i_mmio_rdata = $urandom;
    end
  end

  // Monitor: responses, RAM writes and MMIO beats against the expectation queues.
  initial begin
    resp_t r;
    acc_t  m;
    logic        pv = 1'b0, phs = 1'b0, pwe = 1'b0;
    logic [31:0] pa = '0, pw = '0;
    forever begin
      @(negedge i_clk);
      if (o_resp_valid) begin
        if (resp_q.size() == 0) begin
          fail_now($sformatf("unexpected_resp: resp_valid=1 rd=%0d, required no response", o_resp_rd));
        end else begin
          r = resp_q.pop_front();
          check("resp_rd", 32'(o_resp_rd), 32'(r.rd));
          check("resp_fault", 32'(o_resp_fault), 32'(r.fault));
          if (r.via_mmio) begin
            check("resp_rdata_mmio", o_resp_rdata, r.we ? 32'h0 : hs_rdata);
            check("resp_cycle_mmio", 32'(cyc), 32'(hs_cyc + 1));
          end else begin
            check("resp_rdata", o_resp_rdata, r.rdata);
            check("resp_cycle", 32'(cyc), 32'(r.exp_cyc));
          end
        end
      end
      if (o_mem_wr_en) begin
        if (wr_q.size() == 0) begin
          fail_now($sformatf("unexpected_write: mem_wr_en=1 addr=0x%08h, required 0", o_mem_addr));
        end else begin
          m = wr_q.pop_front();
          check("wr_addr", o_mem_addr, m.addr);
          check("wr_wdata", o_mem_wdata, m.wdata);
          check("wr_fn3", 32'(o_mem_fn3), 32'(m.fn3));
          check("wr_cycle", 32'(cyc), 32'(m.cyc));
        end
      end
      if (o_mmio_valid) begin
        if (!pv || phs) begin
          if (mmio_q.size() == 0) begin
            fail_now($sformatf("unexpected_mmio: mmio_valid=1 addr=0x%08h, required 0", o_mmio_addr));
          end else begin
            m = mmio_q.pop_front();
            check("mmio_addr", o_mmio_addr, m.addr);
            check("mmio_wdata", o_mmio_wdata, m.wdata);
            check("mmio_we", 32'(o_mmio_we), 32'(m.we));
            check("mmio_start_cycle", 32'(cyc), 32'(m.cyc));
          end
        end else begin
          check("mmio_addr_stable", o_mmio_addr, pa);
          check("mmio_wdata_stable", o_mmio_wdata, pw);
          check("mmio_we_stable", 32'(o_mmio_we), 32'(pwe));
        end
        if (i_mmio_ready) begin
          hs_cyc   = cyc;
          hs_rdata = i_mmio_rdata;
        end
      end
      pv  = o_mmio_valid;
      phs = o_mmio_valid && i_mmio_ready;
      pa  = o_mmio_addr;
      pw  = o_mmio_wdata;
      pwe = o_mmio_we;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic we,
                       input logic [2:0] f, input logic [4:0] rd, input bit push_resp);
    logic [1:0]  flt;
    int          kind;
    logic [31:0] off;
    int          acc;
    bit          got;
    resp_t       r;
    acc_t        m;
    model(a, we, f, flt, kind, off);
    @(posedge i_clk);
    #1;
    i_req_addr  = a;
    i_req_wdata = wd;
    i_req_we    = we;
    i_req_fn3   = f;
    i_req_rd    = rd;
    i_req_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge i_clk);
      if (o_req_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      fail_now("req_ready_timeout: req_ready stayed 0, required 1 within 60 cycles");
      i_req_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    r.rd = rd; r.fault = flt; r.we = we; r.via_mmio = (kind == 2); r.rdata = '0;
    r.exp_cyc = (kind == 0) ? acc : (we ? acc + 1 : acc + 2);
    if (kind == 1 && !we) r.rdata = ram_fmt(off, f);
    if (push_resp) resp_q.push_back(r);
    m.addr = off; m.wdata = wd; m.fn3 = f; m.we = we; m.cyc = acc;
    if (kind == 1 && we && push_resp) wr_q.push_back(m);
    if (kind == 2) mmio_q.push_back(m);
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    i_req_addr  = $urandom;
    i_req_wdata = $urandom;
    i_req_fn3   = 3'($urandom_range(0, 7));
    if (kind == 1 && !we) begin
      for (int k = 0; k < 2; k++) begin
        @(negedge i_clk);
        check("ld_mem_addr_held", o_mem_addr, off);
        check("ld_mem_fn3_held", 32'(o_mem_fn3), 32'(f));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bnd[8];
    logic [31:0] a;
    int          region;
    bnd[0] = 32'h8000_1FFF; bnd[1] = 32'h8000_A000; bnd[2] = 32'h8000_9FFC; bnd[3] = 32'h0FFF_FFFC;
    bnd[4] = 32'h1000_0100; bnd[5] = 32'h1000_00FC; bnd[6] = 32'h0000_0000; bnd[7] = 32'hFFFF_FFFC;

    i_rst = 1'b1;
    i_req_valid = 1'b0; i_req_addr = '0; i_req_wdata = '0;
    i_req_we = 1'b0; i_req_fn3 = '0; i_req_rd = '0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("ready_in_reset", 32'(o_req_ready), 32'h0);
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_resp_valid", 32'(o_resp_valid), 32'h0);
    check("rst_mem_wr_en", 32'(o_mem_wr_en), 32'h0);
    check("rst_mmio_valid", 32'(o_mmio_valid), 32'h0);
    check("rst_resp_rdata", o_resp_rdata, 32'h0);
    check("rst_resp_fault", 32'(o_resp_fault), 32'h0);
    check("rst_resp_rd", 32'(o_resp_rd), 32'h0);
    check("rst_req_ready", 32'(o_req_ready), 32'h1);

    issue(32'h8000_2010, 32'h0, 1'b0, 3'd2, 5'd7, 1'b1);
    issue(32'h8000_2003, 32'h55, 1'b1, 3'd0, 5'd8, 1'b1);
    hold_lo = 7;
    issue(32'h1000_0004, 32'h41, 1'b1, 3'd2, 5'd9, 1'b1);
    issue(32'h8000_2001, 32'h0, 1'b0, 3'd1, 5'd10, 1'b1);
    issue(32'h8000_2006, 32'h1234, 1'b1, 3'd2, 5'd11, 1'b1);
    issue(32'h1000_0000, 32'h0, 1'b0, 3'd0, 5'd12, 1'b1);
    issue(32'h0000_0000, 32'h0, 1'b0, 3'd2, 5'd13, 1'b1);
    issue(32'h8000_9FFC, 32'h0, 1'b0, 3'd2, 5'd14, 1'b1);
    issue(32'h8000_A000, 32'h0, 1'b0, 3'd2, 5'd15, 1'b1);
    issue(32'h1000_00FC, 32'h0, 1'b0, 3'd2, 5'd16, 1'b1);
    issue(32'h1000_0100, 32'h77, 1'b1, 3'd2, 5'd17, 1'b1);
    issue(32'h8000_2000, 32'h99, 1'b1, 3'd3, 5'd18, 1'b1);
    issue(32'h8000_2005, 32'h0, 1'b0, 3'd4, 5'd19, 1'b1);

    // Reset while a RAM store sits in its access cycle.
    issue(32'h8000_2020, 32'hCAFE_F00D, 1'b1, 3'd2, 5'd20, 1'b0);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("rst_store_suppressed", 32'(o_mem_wr_en), 32'h0);
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    check("ready_after_rst_store", 32'(o_req_ready), 32'h1);

    // Reset while an MMIO load waits for ready.
    hold_lo = 12;
    issue(32'h1000_0008, 32'h0, 1'b0, 3'd2, 5'd21, 1'b0);
    @(negedge i_clk);
    check("mmio_valid_waiting", 32'(o_mmio_valid), 32'h1);
    @(posedge i_clk);
    #1 i_rst = 1'b1;
    @(negedge i_clk);
    check("mmio_dropped_in_rst", 32'(o_mmio_valid), 32'h0);
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    check("ready_after_rst_mmio", 32'(o_req_ready), 32'h1);
    check("mmio_idle_after_rst", 32'(o_mmio_valid), 32'h0);
    hold_lo = 0;

    for (int n = 0; n < 300; n++) begin
      region = $urandom_range(0, 9);
      if (region <= 4)      a = 32'(RAM_B) + $urandom_range(0, 32767);
      else if (region <= 6) a = 32'(MMIO_B) + $urandom_range(0, 255);
      else if (region == 7) a = bnd[$urandom_range(0, 7)];
      else                  a = $urandom;
      issue(a, $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            5'($urandom_range(0, 31)), 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge i_clk);
    end

    for (int i = 0; i < 200; i++) begin
      if (resp_q.size() == 0 && wr_q.size() == 0 && mmio_q.size() == 0) break;
      @(negedge i_clk);
    end
    repeat (4) @(negedge i_clk);
    check("resp_queue_drained", 32'(resp_q.size()), 32'h0);
    check("write_queue_drained", 32'(wr_q.size()), 32'h0);
    check("mmio_queue_drained", 32'(mmio_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
